fpnew_simd_lane_collector: RTL and testbench
============================================

// Module: fpnew_simd_lane_collector
// PURPOSE
// - Output-side collector for multi-lane FP slices whose lanes finish out of step (variable latency, per-lane backpressure).
// - Each lane has its own valid/ready handshake; results are captured per lane and assembled once every active lane has delivered.
// - The assembled word is NaN-boxed, sign-extended, status-collapsed and pushed into a Depth-entry output FIFO.
// - Sits between the lane instances and the opgroup output arbiter, replacing lane-0-only handshaking.
// PARAMETERS
// - Width     64  total slice datapath width in bits
// - FpWidth   16  per-lane FP width; NUM_LANES = Width/FpWidth (localparam); Width%FpWidth!=0 is an elaboration error
// - Depth     2   output FIFO entries; >=1
// - TagWidth  8   width of the opaque operation tag
// PORTS
// - clk_i          in   1                    clock
// - rst_ni         in   1                    asynchronous active-low reset
// - flush_i        in   1                    drop all held and queued results
// - lane_valid_i   in   NUM_LANES            per-lane result valid
// - lane_ready_o   out  NUM_LANES            per-lane result ready
// - lane_result_i  in   NUM_LANES*FpWidth    lane l result at [l*FpWidth +: FpWidth]
// - lane_status_i  in   NUM_LANES*5          fpnew status {NV,DZ,OF,UF,NX} per lane
// - lane_mask_i    in   NUM_LANES            SIMD mask bit; status of masked-off lanes is ignored
// - meta_i         in   TagWidth+3           {tag, vectorial, cmp, ext_bit}; sampled with lane 0 only
// - result_o       out  Width                assembled result
// - status_o       out  5                    OR of active, unmasked lane status
// - ext_bit_o      out  1                    extension bit of the head entry
// - tag_o          out  TagWidth             tag of the head entry
// - out_valid_o    out  1                    head entry valid
// - out_ready_i    in   1                    downstream accept
// - busy_o         out  1                    any hold register or FIFO entry occupied
// BEHAVIOUR
// - Reset: all hold_valid=0, FIFO empty; out_valid_o=0, busy_o=0, lane_ready_o=0 during reset, all other outputs 0.
// - Per lane l: one hold register {result, status, mask}; lane 0 also holds meta.
// - lane_ready_o[l] = ~flush_i & (~hold_valid[l] | (fire & active[l])).
// - Handshake on lane l: lane_valid_i[l] & lane_ready_o[l]; hold is written and hold_valid[l] set at the next edge.
// - Active set: vectorial=1 -> all lanes; vectorial=0 -> lane 0 only.
// - fire = hold_valid[0] & (all active lanes held) & (~fifo_full | pop).
// - On fire: push the assembled entry and clear hold_valid for the active lanes; inactive holds are kept for the next op.
// - A lane may refill on the same edge it is consumed.
// - Assembly, per lane l:
//   - active: slot = held result.
//   - inactive: slot = {FpWidth{ext_bit}}.
//   - status = OR over active l of status[l] & {5{mask[l]}}.
// - Latency: final lane handshake at edge t -> fire in cycle t+1 -> out_valid_o=1 from cycle t+2 (minimum 2 cycles).
// - Throughput: one assembled result per cycle while out_ready_i=1.
// - FIFO: head-registered, in-order.
//   - pop = out_valid_o & out_ready_i.
//   - Simultaneous pop and fire on a full FIFO is legal; occupancy is unchanged.
//   - Full without pop: fire stalls, holds stay, lane_ready_o of held lanes stays 0.
//   - Empty: out_valid_o=0; result_o, status_o and tag_o are don't-care.
// - Pointers wrap modulo Depth; occupancy counter is $clog2(Depth+1) bits.
// - flush_i: at the next edge clear all hold_valid and empty the FIFO.
//   - No fire and no lane capture in the flush cycle.
//   - out_valid_o=0 from the following cycle.
// - Reset asserted mid-operation: same effect as flush, asynchronous.
// CONFIGURATION
// - Macro FPNEW_LANE_COLLECTOR_CMPCOMP_EN.
// - Defined: if the entry has cmp=1 and vectorial=1, result_o = {zero-pad, bit0 of each lane slot, lane 0 at bit 0} (NUM_LANES LSBs).
// - Undefined: compare results stay in their lane slots like every other op.
// TESTING
// - Width=64,FpWidth=16, scalar: lane0 0x3C00, meta ext=1, tag=5 -> cycle+2 result_o=0xFFFF_FFFF_FFFF_3C00, tag_o=5.
// - Vector, lanes arriving in order 3,1,0,2 on separate cycles -> a single output only after lane 2 + 2 cycles, slots correct.
// - Depth=2, out_ready_i=0, 3 vector ops -> two entries queued, lane_ready_o=0 for third-op held lanes; release -> 3 in-order outputs.
// - lane 1 status NX with mask=0, lane 2 status OF with mask=1 -> status_o=OF only.
// - flush_i with 2 queued entries and 3 held lanes -> out_valid_o=0 and busy_o=0 the next cycle; new op completes normally.
// - Macro defined, vector cmp with lane bit0 = 1,0,1,1 (lanes 0..3) -> result_o=0x...000D; macro undefined -> lane slots unchanged.

Source files
------------

// File: rtl/fpnew_simd_lane_collector.sv
// Collects per-lane FP results that arrive out of step, assembles NaN-boxed SIMD words and queues them.
// Optional macro FPNEW_LANE_COLLECTOR_CMPCOMP_EN packs vectorial compare results into the low bits.
module fpnew_simd_lane_collector #(
   parameter  int unsigned Width     = 64,
   parameter  int unsigned FpWidth   = 16,
   parameter  int unsigned Depth     = 2,
   parameter  int unsigned TagWidth  = 8,
   localparam int unsigned NUM_LANES = Width / FpWidth
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic [NUM_LANES-1:0]         lane_valid_i,
   output logic [NUM_LANES-1:0]         lane_ready_o,
   input  logic [NUM_LANES*FpWidth-1:0] lane_result_i,
   input  logic [NUM_LANES*5-1:0]       lane_status_i,
   input  logic [NUM_LANES-1:0]         lane_mask_i,
   input  logic [TagWidth+2:0]          meta_i,
   output logic [Width-1:0]             result_o,
   output logic [4:0]                   status_o,
   output logic                         ext_bit_o,
   output logic [TagWidth-1:0]          tag_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic                         busy_o
);

   localparam int unsigned MetaW = TagWidth + 3;
   localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW  = $clog2(Depth + 1);

   if ((Width % FpWidth) != 0 || Width < FpWidth) begin : g_bad_width
      $error("Width must be a non-zero multiple of FpWidth");
   end
   if (Depth < 1) begin : g_bad_depth
      $error("Depth must be at least 1");
   end

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   logic [NUM_LANES-1:0] r_hold_valid;
   logic [NUM_LANES-1:0] r_hold_mask;
   logic [FpWidth-1:0]   r_hold_res  [NUM_LANES];
   logic [4:0]           r_hold_stat [NUM_LANES];
   logic [MetaW-1:0]     r_meta;

   logic [Width-1:0]     r_fifo_res  [Depth];
   logic [4:0]           r_fifo_stat [Depth];
   logic                 r_fifo_ext  [Depth];
   logic [TagWidth-1:0]  r_fifo_tag  [Depth];
   logic [PtrW-1:0]      r_wr_ptr, r_rd_ptr;
   logic [CntW-1:0]      r_count;

   logic                 w_vec, w_ext, w_full, w_pop, w_fire;
   logic [NUM_LANES-1:0] w_active, w_take;
   logic [FpWidth-1:0]   w_slot     [NUM_LANES];
   logic [4:0]           w_stat_acc [NUM_LANES+1];
   logic [Width-1:0]     w_slots, w_asm_res;

   // Handshake and fire decision: meta always comes from the lane-0 hold.
   assign w_vec    = r_meta[2];
   assign w_ext    = r_meta[0];
   assign w_active = w_vec ? {NUM_LANES{1'b1}} : NUM_LANES'(1);
   assign w_full   = (r_count == CntW'(Depth));
   assign w_pop    = out_valid_o & out_ready_i;
   assign w_fire   = ~flush_i & r_hold_valid[0] & (&(r_hold_valid | ~w_active)) & (~w_full | w_pop);

   assign lane_ready_o = {NUM_LANES{rst_ni & ~flush_i}} &
                         (~r_hold_valid | ({NUM_LANES{w_fire}} & w_active));
   assign w_take       = lane_valid_i & lane_ready_o;

   assign w_stat_acc[0] = '0;
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      assign w_slot[l] = w_active[l] ? r_hold_res[l] : {FpWidth{w_ext}};
      assign w_slots[l*FpWidth +: FpWidth] = w_slot[l];
      assign w_stat_acc[l+1] = w_stat_acc[l] |
                               (r_hold_stat[l] & {5{w_active[l] & r_hold_mask[l]}});

      always_ff @(posedge clk_i) begin
         if (w_take[l]) begin
            r_hold_res[l]  <= lane_result_i[l*FpWidth +: FpWidth];
            r_hold_stat[l] <= lane_status_i[l*5 +: 5];
            r_hold_mask[l] <= lane_mask_i[l];
         end
      end
   end

`ifdef FPNEW_LANE_COLLECTOR_CMPCOMP_EN
   logic [NUM_LANES-1:0] w_cmp_bits;
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_cmp
      assign w_cmp_bits[l] = w_slot[l][0];
   end
   assign w_asm_res = (r_meta[1] & w_vec) ? Width'(w_cmp_bits) : w_slots;
`else
   logic w_unused_cmp;
   assign w_unused_cmp = r_meta[1];
   assign w_asm_res    = w_slots;
`endif

   always_ff @(posedge clk_i) begin
      if (w_take[0]) r_meta <= meta_i;
   end

   // Active holds release on fire; a handshake on the same edge refills them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      r_hold_valid <= '0;
      else if (flush_i) r_hold_valid <= '0;
      else              r_hold_valid <= w_take | (r_hold_valid & ~({NUM_LANES{w_fire}} & w_active));
   end

   // Output FIFO: pointer/count control is reset, storage is not.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_fire) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_fire, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_fire) begin
         r_fifo_res[r_wr_ptr]  <= w_asm_res;
         r_fifo_stat[r_wr_ptr] <= w_stat_acc[NUM_LANES];
         r_fifo_ext[r_wr_ptr]  <= w_ext;
         r_fifo_tag[r_wr_ptr]  <= r_meta[MetaW-1:3];
      end
   end

   assign out_valid_o = (r_count != '0);
   assign result_o    = out_valid_o ? r_fifo_res[r_rd_ptr]  : '0;
   assign status_o    = out_valid_o ? r_fifo_stat[r_rd_ptr] : '0;
   assign ext_bit_o   = out_valid_o ? r_fifo_ext[r_rd_ptr]  : 1'b0;
   assign tag_o       = out_valid_o ? r_fifo_tag[r_rd_ptr]  : '0;
   assign busy_o      = (|r_hold_valid) | out_valid_o;

endmodule

// File: tb/tb_fpnew_simd_lane_collector.sv
// Directed bench for fpnew_simd_lane_collector (Width=64, FpWidth=16, Depth=2, TagWidth=8).
module tb_fpnew_simd_lane_collector;

   logic        clk = 1'b0;
   logic        rst_n, flush;
   logic [3:0]  lv, lm, lrdy;
   logic [63:0] lres, res_o;
   logic [19:0] lstat;
   logic [10:0] meta;
   logic [4:0]  stat_o;
   logic        ext_o, ov, ordy, busy;
   logic [7:0]  tag_o;
   int          n_vec = 0;
   int          n_err = 0;

   fpnew_simd_lane_collector #(.Width(64), .FpWidth(16), .Depth(2), .TagWidth(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .lane_valid_i(lv), .lane_ready_o(lrdy), .lane_result_i(lres),
      .lane_status_i(lstat), .lane_mask_i(lm), .meta_i(meta),
      .result_o(res_o), .status_o(stat_o), .ext_bit_o(ext_o), .tag_o(tag_o),
      .out_valid_o(ov), .out_ready_i(ordy), .busy_o(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end of the directed sequence");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [10:0] mk_meta(input logic [7:0] t, input logic v, input logic c, input logic e);
      return {t, v, c, e};
   endfunction

   // Present one handshake on the lanes in v; they must all be ready.
   task automatic issue(input logic [3:0] v, input logic [63:0] r, input logic [19:0] s,
                        input logic [3:0] m, input logic [10:0] md, input string tg);
      lv = v; lres = r; lstat = s; lm = m; meta = md;
      #1 chk({tg, "_rdy"}, 64'(lrdy & v), 64'(v));
      cyc();
      lv = '0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; lv = 4'hF; lm = '0; lres = '0; lstat = '0; meta = '0; ordy = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_rdy",  64'(lrdy), 64'h0);
      chk("rst_ov",   64'(ov),   64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_res",  res_o,     64'h0);
      chk("rst_tag",  64'(tag_o), 64'h0);
      chk("rst_stat", 64'(stat_o), 64'h0);
      lv = '0; rst_n = 1'b1;
      cyc();
      chk("post_rst_rdy", 64'(lrdy), 64'hF);

      // Scalar op: inactive slots filled with the ext bit
      issue(4'b0001, 64'h3C00, 20'h0, 4'b0001, mk_meta(8'd5, 1'b0, 1'b0, 1'b1), "sc");
      chk("sc_ov_early", 64'(ov), 64'h0);
      cyc();
      chk("sc_ov",   64'(ov),    64'h1);
      chk("sc_res",  res_o,      64'hFFFF_FFFF_FFFF_3C00);
      chk("sc_tag",  64'(tag_o), 64'h5);
      chk("sc_ext",  64'(ext_o), 64'h1);
      chk("sc_stat", 64'(stat_o), 64'h0);
      cyc();
      chk("sc_drain_ov",   64'(ov),   64'h0);
      chk("sc_drain_busy", 64'(busy), 64'h0);

      // Vector op with lanes arriving 3,1,0,2
      issue(4'b1000, 64'h4400_0000_0000_0000, 20'h0, 4'b1000, 11'h0, "v3");
      chk("v3_ov", 64'(ov), 64'h0);
      issue(4'b0010, 64'h0000_0000_4000_0000, 20'h0, 4'b0010, 11'h0, "v1");
      chk("v1_ov", 64'(ov), 64'h0);
      issue(4'b0001, 64'h3C00, 20'h0, 4'b0001, mk_meta(8'd9, 1'b1, 1'b0, 1'b0), "v0");
      chk("v0_ov", 64'(ov), 64'h0);
      issue(4'b0100, 64'h0000_4200_0000_0000, 20'h0, 4'b0100, 11'h0, "v2");
      chk("v2_ov", 64'(ov), 64'h0);
      cyc();
      chk("vec_ov",  64'(ov),    64'h1);
      chk("vec_res", res_o,      64'h4400_4200_4000_3C00);
      chk("vec_tag", 64'(tag_o), 64'h9);
      cyc();
      chk("vec_single", 64'(ov), 64'h0);

      // Masked NX on lane 1 ignored, unmasked OF on lane 2 kept
      issue(4'hF, 64'h1, 20'h0_1020, 4'b1101, mk_meta(8'd1, 1'b1, 1'b0, 1'b0), "st");
      cyc();
      chk("st_stat", 64'(stat_o), 64'h04);
      cyc();

      // Inactive lane 1 hold survives a scalar op and joins the next vector op
      issue(4'b0010, 64'h0000_0000_ABCD_0000, 20'h0_0200, 4'b0010, 11'h0, "h1");
      chk("h1_busy", 64'(busy), 64'h1);
      issue(4'b0001, 64'h1234, 20'h0, 4'b0001, mk_meta(8'd3, 1'b0, 1'b0, 1'b1), "hs");
      chk("hs_rdy1", 64'(lrdy[1]), 64'h0);
      cyc();
      chk("hs_res",  res_o,       64'hFFFF_FFFF_FFFF_1234);
      chk("hs_stat", 64'(stat_o), 64'h0);
      chk("hs_tag",  64'(tag_o),  64'h3);
      cyc();
      chk("hs_ov",   64'(ov),   64'h0);
      chk("hs_busy", 64'(busy), 64'h1);
      issue(4'b1101, 64'h3333_2222_0000_1111, 20'h0, 4'b1101, mk_meta(8'd4, 1'b1, 1'b0, 1'b0), "hv");
      cyc();
      chk("hv_res",  res_o,       64'h3333_2222_ABCD_1111);
      chk("hv_stat", 64'(stat_o), 64'h10);
      chk("hv_tag",  64'(tag_o),  64'h4);
      cyc();
      chk("hv_busy", 64'(busy), 64'h0);

      // Backpressure: two queued, third op held with ready low
      ordy = 1'b0;
      issue(4'hF, 64'hA3A3_A2A2_A1A1_A0A0, 20'h0, 4'hF, mk_meta(8'd1, 1'b1, 1'b0, 1'b0), "bpA");
      issue(4'hF, 64'hB3B3_B2B2_B1B1_B0B0, 20'h0, 4'hF, mk_meta(8'd2, 1'b1, 1'b0, 1'b0), "bpB");
      issue(4'hF, 64'hC3C3_C2C2_C1C1_C0C0, 20'h0, 4'hF, mk_meta(8'd3, 1'b1, 1'b0, 1'b0), "bpC");
      chk("bp_rdy0", 64'(lrdy), 64'h0);
      chk("bp_headA", res_o, 64'hA3A3_A2A2_A1A1_A0A0);
      cyc();
      chk("bp_rdy0b", 64'(lrdy), 64'h0);
      chk("bp_ov", 64'(ov), 64'h1);
      ordy = 1'b1;
      #1 chk("bp_outA", res_o, 64'hA3A3_A2A2_A1A1_A0A0);
      chk("bp_tagA", 64'(tag_o), 64'h1);
      cyc();
      chk("bp_outB", res_o, 64'hB3B3_B2B2_B1B1_B0B0);
      chk("bp_tagB", 64'(tag_o), 64'h2);
      cyc();
      chk("bp_outC", res_o, 64'hC3C3_C2C2_C1C1_C0C0);
      chk("bp_tagC", 64'(tag_o), 64'h3);
      cyc();
      chk("bp_empty", 64'(ov), 64'h0);

      // Flush with two queued entries and three held lanes
      ordy = 1'b0;
      issue(4'hF,    64'h1111_1111_1111_1111, 20'h0, 4'hF, mk_meta(8'd1, 1'b1, 1'b0, 1'b0), "flA");
      issue(4'hF,    64'h2222_2222_2222_2222, 20'h0, 4'hF, mk_meta(8'd2, 1'b1, 1'b0, 1'b0), "flB");
      issue(4'b1110, 64'h3333_3333_3333_3333, 20'h0, 4'hE, 11'h0, "flC");
      chk("fl_pre_busy", 64'(busy), 64'h1);
      chk("fl_pre_ov",   64'(ov),   64'h1);
      flush = 1'b1;
      #1 chk("fl_rdy", 64'(lrdy), 64'h0);
      cyc();
      flush = 1'b0;
      chk("fl_ov",   64'(ov),   64'h0);
      chk("fl_busy", 64'(busy), 64'h0);
      #1 chk("fl_rdy_after", 64'(lrdy), 64'hF);
      ordy = 1'b1;
      issue(4'b0001, 64'h5555, 20'h0, 4'b0001, mk_meta(8'd7, 1'b0, 1'b0, 1'b0), "fln");
      cyc();
      chk("fln_res", res_o,      64'h0000_0000_0000_5555);
      chk("fln_tag", 64'(tag_o), 64'h7);
      cyc();

      // Vectorial compare
      issue(4'hF, 64'h0005_0003_0002_0001, 20'h0, 4'hF, mk_meta(8'd8, 1'b1, 1'b1, 1'b0), "cmp");
      cyc();
`ifdef FPNEW_LANE_COLLECTOR_CMPCOMP_EN
      chk("cmp_res", res_o, 64'h0000_0000_0000_000D);
`else
      chk("cmp_res", res_o, 64'h0005_0003_0002_0001);
`endif
      cyc();
      chk("end_busy", 64'(busy), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
